// File: rtl/fpr_wb_arbiter.sv
// fpr_wb_arbiter
//
// Purpose:
//   Shares the single write port of the 32x32 floating-point register file
//   among N_REQ writeback requesters using round-robin arbitration with a
//   valid/ready handshake. The winning write is registered onto the
//   register-file write port. A 32-bit busy scoreboard tracks registers with
//   outstanding producers: issue sets a bit, a committed write clears it.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   req_valid    in   [N_REQ]       requester i has a write pending
//   req_addr     in   [N_REQ*AW]    destination of requester i, slice [i*AW +: AW]
//   req_data     in   [N_REQ*DW]    write data of requester i, slice [i*DW +: DW]
//   req_ready    out  [N_REQ]       one-hot grant (combinational)
//   issue_valid  in                 mark issue_addr busy
//   issue_addr   in   [AW]          register being allocated
//   fpr_we       out                register-file write enable (registered)
//   fpr_wa       out  [AW]          register-file write address (registered)
//   fpr_wd       out  [DW]          register-file write data (registered)
//   fpr_busy     out  [32]          busy scoreboard, bit r = pending write to r

module fpr_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  fpr_we,
  output logic [AW-1:0]         fpr_wa,
  output logic [DW-1:0]         fpr_wd,
  output logic [31:0]           fpr_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          fpr_we_q, fpr_we_d;
  logic [AW-1:0] fpr_wa_q, fpr_wa_d;
  logic [DW-1:0] fpr_wd_q, fpr_wd_d;
  logic [31:0]   busy_q, busy_d;

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;

  logic [AW-1:0] addr_arr [N_REQ];
  logic [DW-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  // Round-robin search starting at ptr_q; the first valid requester wins.
  // Reset suppresses every grant so nothing is accepted while in reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = PW'((int'(ptr_q) + k) % N_REQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // A grant always coincides with valid, so grant_found is the handshake.
  always_comb begin
    ptr_d    = ptr_q;
    fpr_we_d = grant_found;
    fpr_wa_d = fpr_wa_q;
    fpr_wd_d = fpr_wd_q;
    if (grant_found) begin
      fpr_wa_d = addr_arr[grant_idx];
      fpr_wd_d = data_arr[grant_idx];
      if (grant_idx == PW'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PW'(1);
      end
    end
  end

  // Clear for the write currently on the port first, then set for a new
  // producer, so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (fpr_we_q) begin
      busy_d[fpr_wa_q] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      fpr_we_q <= 1'b0;
      fpr_wa_q <= '0;
      fpr_wd_q <= '0;
      busy_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      fpr_we_q <= fpr_we_d;
      fpr_wa_q <= fpr_wa_d;
      fpr_wd_q <= fpr_wd_d;
      busy_q   <= busy_d;
    end
  end

  // The register file writes on the falling edge inside the cycle, so a
  // write accepted just before reset is masked here and never lands.
  assign fpr_we   = fpr_we_q & ~rst;
  assign fpr_wa   = fpr_wa_q;
  assign fpr_wd   = fpr_wd_q;
  assign fpr_busy = busy_q;

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// tb_fpr_wb_arbiter
//
// Purpose:
//   Scoreboard bench for fpr_wb_arbiter. Each cycle the stimulus side works
//   out the expected grant, busy vector and registered write from a
//   behavioural model and pushes the expected write-port contents; a
//   separate monitor pops and compares them when the write port updates.

module tb_fpr_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              issue_valid = 1'b0;
  logic [AW-1:0]     issue_addr = '0;
  logic              fpr_we;
  logic [AW-1:0]     fpr_wa;
  logic [DW-1:0]     fpr_wd;
  logic [31:0]       fpr_busy;

  always #5 clk = ~clk;

  fpr_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .fpr_we(fpr_we), .fpr_wa(fpr_wa), .fpr_wd(fpr_wd), .fpr_busy(fpr_busy)
  );

  typedef struct {
    bit            we;
    bit [AW-1:0]   wa;
    bit [DW-1:0]   wd;
    int            stamp;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cycle  = 0;

  // Requester-side intent, copied onto the DUT pins by applyStimulus.
  bit [N-1:0]    st_valid = '0;
  bit [N*AW-1:0] st_addr  = '0;
  bit [N*DW-1:0] st_data  = '0;
  int            last_grant = -1;

  // Behavioural model: priority pointer, set of busy registers, and the
  // write currently presented on the register-file port.
  int            m_ptr = 0;
  bit [31:0]     m_busy = '0;
  bit            m_cur_we = 1'b0;
  bit [AW-1:0]   m_wa = '0;
  bit [DW-1:0]   m_wd = '0;

  always @(posedge clk) cycle <= cycle + 1;

  // Requesters must hold valid, address and data until accepted.
  for (genvar i = 0; i < N; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_addr[i*AW +: AW]) && $stable(req_data[i*DW +: DW])))
    else begin
      errors++;
      $display("[TB] FAIL hold_rule requester %0d dropped or changed its request", i);
    end
  end

  function automatic int modelGrant(bit [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, predict the grant,
  // next busy vector and next write-port contents, check at the falling edge.
  task automatic applyStimulus(input bit r, input bit iv, input bit [AW-1:0] ia);
    int          g;
    wr_t         nxt;
    bit [31:0]   b;
    bit [N-1:0]  exp_ready;
    @(posedge clk);
    #1;
    rst         = r;
    req_valid   = st_valid;
    req_addr    = st_addr;
    req_data    = st_data;
    issue_valid = iv;
    issue_addr  = ia;
    g = r ? -1 : modelGrant(st_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    nxt.stamp = cycle;
    if (r) begin
      nxt.we = 1'b0; nxt.wa = '0; nxt.wd = '0;
    end else if (g >= 0) begin
      nxt.we = 1'b1; nxt.wa = st_addr[g*AW +: AW]; nxt.wd = st_data[g*DW +: DW];
    end else begin
      nxt.we = 1'b0; nxt.wa = m_wa; nxt.wd = m_wd;
    end
    exp_q.push_back(nxt);
    b = '0;
    if (!r) begin
      b = m_busy;
      if (m_cur_we) b[m_wa] = 1'b0;
      if (iv) b[ia] = 1'b1;
    end
    @(negedge clk);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("fpr_busy", fpr_busy, m_busy);
    m_busy     = b;
    m_cur_we   = nxt.we;
    m_wa       = nxt.wa;
    m_wd       = nxt.wd;
    if (r) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % N;
    last_grant = g;
  endtask

  task automatic newReq(input int i);
    st_addr[i*AW +: AW] = AW'($urandom_range(31));
    st_data[i*DW +: DW] = $urandom;
  endtask

  // Retire outstanding requests one grant at a time without breaking hold.
  task automatic drain();
    for (int k = 0; k < N + 1 && st_valid != '0; k++) begin
      if (last_grant >= 0) st_valid[last_grant] = 1'b0;
      if (st_valid != '0) applyStimulus(1'b0, 1'b0, '0);
    end
  endtask

  // Monitor: the write pushed in cycle c must be on the port in cycle c+1,
  // except that a reset in that cycle masks the enable.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].stamp < cycle - 1) begin
        e = exp_q.pop_front();
        checkOutput("stale_write", 64'(e.stamp), 64'(cycle - 1));
      end
      if (exp_q.size() > 0 && exp_q[0].stamp == cycle - 1) begin
        e = exp_q.pop_front();
        checkOutput("fpr_we", fpr_we, e.we && !rst);
        checkOutput("fpr_wa", fpr_wa, e.wa);
        checkOutput("fpr_wd", fpr_wd, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held two cycles with every requester valid.
    st_valid = '1;
    for (int i = 0; i < N; i++) newReq(i);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_we", fpr_we, 0);
    checkOutput("rst_wa", fpr_wa, 0);
    checkOutput("rst_busy", fpr_busy, 0);

    // First grant after release goes to 0, then strict rotation.
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("first_grant", req_ready, 64'd1);
    for (int k = 0; k < 6; k++) begin
      newReq(last_grant);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("rr_grant", req_ready, 64'd1 << ((k + 1) % N));
      checkOutput("rr_we", fpr_we, 1);
    end
    drain();

    // Single request from requester 1.
    st_valid = 3'b010;
    st_addr[1*AW +: AW] = 5'd7;
    st_data[1*DW +: DW] = 32'h3F80_0000;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("single_ready", req_ready, 64'b010);
    st_valid = '0;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("single_we", fpr_we, 1);
    checkOutput("single_wa", fpr_wa, 7);
    checkOutput("single_wd", fpr_wd, 64'h3F80_0000);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("single_we_off", fpr_we, 0);

    // Pointer now 2: requester 0 wins by wrap, then requester 1.
    st_valid = 3'b011;
    newReq(0); newReq(1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wrap_grant0", req_ready, 64'b001);
    st_valid = 3'b010;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wrap_grant1", req_ready, 64'b010);
    st_valid = '0;
    applyStimulus(1'b0, 1'b0, '0);

    // Scoreboard: issue f5, write f5, busy clears one edge after the write.
    applyStimulus(1'b0, 1'b1, 5'd5);
    st_valid = 3'b001;
    st_addr[0 +: AW] = 5'd5;
    st_data[0 +: DW] = $urandom;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("busy5_set", fpr_busy[5], 1);
    st_valid = '0;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("busy5_during_we", fpr_busy[5], 1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("busy5_cleared", fpr_busy[5], 0);
    // Re-issue of f5 in its own clear cycle keeps it busy.
    applyStimulus(1'b0, 1'b1, 5'd5);
    st_valid = 3'b001;
    applyStimulus(1'b0, 1'b0, '0);
    st_valid = '0;
    applyStimulus(1'b0, 1'b1, 5'd5);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("busy5_set_wins", fpr_busy[5], 1);

    // Reset right after a handshake: the write is masked and busy clears.
    st_valid = 3'b100;
    newReq(2);
    applyStimulus(1'b0, 1'b1, 5'd9);
    st_valid = '0;
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("midrst_we", fpr_we, 0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("midrst_we_after", fpr_we, 0);
    checkOutput("midrst_busy", fpr_busy, 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      bit r;
      r = ($urandom_range(79) == 0);
      for (int i = 0; i < N; i++) begin
        if (!st_valid[i] || i == last_grant) begin
          st_valid[i] = 1'($urandom_range(1));
          newReq(i);
        end
      end
      applyStimulus(r, ($urandom_range(2) == 0), AW'($urandom_range(31)));
    end
    drain();
    st_valid = '0;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk);
    #2;
    checkOutput("queue_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
